spart_key_decoder: RTL
======================

// Module: spart_key_decoder
// PURPOSE
//  Downstream consumer of the spart receive path. After reset it programs the baud
//    divisor through the spart bus.
//  It then polls rda, reads each received byte and maps ASCII keys to game commands.
//  Commands are buffered in a small FIFO and offered to game logic on a valid/ready handshake.
// PARAMETERS
//  DIVISOR     16'h0145  baud divisor written to spart after reset (low byte first)
//  FIFO_DEPTH  4         command FIFO entries; power of two, 2..16
// PORTS
//  clk          in    1  system clock
//  rst          in    1  synchronous, active-high reset
//  rda          in    1  spart receive-data-available
//  ioaddr       out   2  spart register select: 00=rx buf, 01=idle/status, 10=div lo, 11=div hi
//  databus      inout 8  spart data bus; driven only while ioaddr is 10 or 11, else 8'hZZ
//  cmd_valid    out   1  FIFO head holds a command
//  cmd          out   3  FIFO head: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DROP, 4 PAUSE
//  cmd_ready    in    1  consumer accepts head when cmd_valid & cmd_ready
//  init_done    out   1  divisor programmed; stays high until rst
//  overflow     out   1  sticky: a valid key was dropped because the FIFO was full
//  bad_key_cnt  out   8  count of unmapped bytes; saturates at 8'hFF
// BEHAVIOUR
//  Clock and reset: single clock domain. The reset is synchronous and active-high.
//  Reset values:
//    - ioaddr=01, databus=Z
//    - cmd_valid=0, cmd=0
//    - init_done=0, overflow=0, bad_key_cnt=0
//    - FIFO empty, state=INIT_LO
//  FSM, one state per cycle unless noted:
//    INIT_LO: ioaddr=10, drive DIVISOR[7:0]. -> INIT_HI.
//    INIT_HI: ioaddr=11, drive DIVISOR[15:8]. -> IDLE, and init_done=1 from next cycle.
//    IDLE:    ioaddr=01, bus released. If rda=1 -> READ, else stay in IDLE.
//    READ:    ioaddr=00 for exactly one cycle. The byte on databus is captured at the end
//             of the cycle, which also clears spart rda. -> DECODE.
//    DECODE:  ioaddr=01. Map the captured byte, push it or drop it. -> IDLE.
//             rda is not sampled in DECODE. A still-high rda is seen in IDLE next cycle.
//  Key map (lowercase ASCII):
//    - 'a' 8'h61 -> LEFT; 'd' 8'h64 -> RIGHT; 'w' 8'h77 -> ROTATE
//    - 's' 8'h73 -> DROP; 'p' 8'h70 -> PAUSE
//    - any other byte -> no push; bad_key_cnt += 1 (saturating)
//  Latency: rda high in IDLE at cycle n -> READ n+1 -> DECODE n+2.
//    If the FIFO was empty, cmd_valid=1 at n+3. There is no bypass path.
//  Throughput: at most one byte per 3 cycles. The bus never stalls on a full FIFO:
//    the byte is always read so rda clears.
//  FIFO:
//    - pop on cmd_valid & cmd_ready
//    - push on a mapped key in DECODE
//    - full and push without pop: the key is dropped and overflow=1
//    - full with push and pop in the same cycle: both happen, no overflow
//    - empty with push and pop in the same cycle: not possible, since cmd_valid=0
//    - pointers are log2(FIFO_DEPTH) bits plus a wrap bit and wrap naturally
//  cmd is stable while cmd_valid=1 and not popped.
//  rda high during INIT_*: ignored until IDLE.
//  Reset mid-operation, any state: next cycle is INIT_LO.
//    The FIFO is flushed, the divisor is rewritten and counters are cleared.
//    A byte pending in spart is then read normally.
// CONFIGURATION
//  CASE_FOLD_EN defined: uppercase 'A' 41, 'D' 44, 'W' 57, 'S' 53, 'P' 50 map to the same
//    commands as lowercase, and do not count as bad keys.
//  CASE_FOLD_EN undefined: uppercase bytes are unmapped and increment bad_key_cnt.
// TESTING
//  1. Release rst -> cycle 1 ioaddr=10 databus=8'h45; cycle 2 ioaddr=11 databus=8'h01.
//     Cycle 3: init_done=1, databus=Z.
//  2. rda pulse with byte 8'h61, cmd_ready=1 -> READ 1 cycle later, cmd_valid=1 with cmd=0
//     3 cycles after rda; popped next cycle.
//  3. cmd_ready=0; bytes 'a','d','w','s','p' -> first 4 queued (cmd 0,1,2,3), 'p' dropped,
//     overflow=1. Drain yields 0,1,2,3 in order.
//  4. Bytes 8'h41, 8'h7A -> CASE_FOLD_EN undefined: bad_key_cnt=2, no cmd_valid.
//     CASE_FOLD_EN defined: cmd=0 pushed, bad_key_cnt=1.
//  5. 300 unmapped bytes -> bad_key_cnt saturates at 8'hFF.
//  6. Assert rst while in READ with 2 queued commands -> next cycle INIT_LO, cmd_valid=0,
//     overflow=0; the divisor sequence repeats.

Source files
------------

// File: rtl/spart_key_decoder.sv
// spart_key_decoder
// Programs the spart baud divisor after reset, then polls rda, reads each
// received byte, maps ASCII keys to game commands and queues them in a small
// FIFO offered to game logic on a valid/ready handshake.
// Build option: CASE_FOLD_EN -- uppercase A/D/W/S/P map like their lowercase keys.
`timescale 1ns/1ps

module spart_key_decoder #(
    parameter logic [15:0] DIVISOR    = 16'h0145,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rda,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       init_done,
    output logic       overflow,
    output logic [7:0] bad_key_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT_LO = 3'd0,
        S_INIT_HI = 3'd1,
        S_IDLE    = 3'd2,
        S_READ    = 3'd3,
        S_DECODE  = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   w_ioaddr;
    logic         w_drive;
    logic [7:0]   w_drive_byte;

    logic [7:0]   r_rx_byte;
    logic [7:0]   w_key;
    logic         w_mapped;
    logic [2:0]   w_code;
    logic         w_push;
    logic         w_bad;

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [2:0]   r_mem [FIFO_DEPTH];
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_wr_en;

    logic         r_init_done;
    logic         r_overflow;
    logic [7:0]   r_bad_cnt;

    // State register: reset always restarts the divisor programming sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and bus control decode
    always_comb begin
        w_state_next = r_state;
        w_ioaddr     = 2'b01;
        w_drive      = 1'b0;
        w_drive_byte = 8'h00;
        case (r_state)
            S_INIT_LO: begin
                w_ioaddr     = 2'b10;
                w_drive      = 1'b1;
                w_drive_byte = DIVISOR[7:0];
                w_state_next = S_INIT_HI;
            end
            S_INIT_HI: begin
                w_ioaddr     = 2'b11;
                w_drive      = 1'b1;
                w_drive_byte = DIVISOR[15:8];
                w_state_next = S_IDLE;
            end
            S_IDLE: begin
                if (rda) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_ioaddr     = 2'b00;
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_INIT_LO;
            end
        endcase
    end

    // While reset is held the bus sits in its idle/released condition
    assign ioaddr  = rst ? 2'b01 : w_ioaddr;
    assign databus = (w_drive && !rst) ? w_drive_byte : 8'hzz;

    // Capture the received byte at the end of the single READ cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_byte <= 8'h00;
        end else if (r_state == S_READ) begin
            r_rx_byte <= databus;
        end
    end

    // Key map; with case folding, uppercase letters are lowered before lookup
    always_comb begin
        w_key    = r_rx_byte;
`ifdef CASE_FOLD_EN
        if (r_rx_byte >= 8'h41 && r_rx_byte <= 8'h5A) begin
            w_key = r_rx_byte | 8'h20;
        end
`endif
        w_mapped = 1'b1;
        w_code   = 3'd0;
        case (w_key)
            8'h61:   w_code = 3'd0;
            8'h64:   w_code = 3'd1;
            8'h77:   w_code = 3'd2;
            8'h73:   w_code = 3'd3;
            8'h70:   w_code = 3'd4;
            default: w_mapped = 1'b0;
        endcase
    end

    assign w_push = (r_state == S_DECODE) && w_mapped;
    assign w_bad  = (r_state == S_DECODE) && !w_mapped;

    // FIFO status: the extra wrap bit separates full from empty
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign cmd_valid = !w_empty;
    assign w_pop     = cmd_valid && cmd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr_en   = w_push && (!w_full || w_pop);

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage, one register per entry
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            // Write the entry addressed by the write pointer
            always_ff @(posedge clk) begin
                if (!rst && w_wr_en && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_mem[gi] <= w_code;
                end
            end
        end
    endgenerate

    // Head is forced to zero while empty so stale entries never show
    assign cmd = cmd_valid ? r_mem[r_rd_ptr[AW-1:0]] : 3'd0;

    // Status flags and bad key counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
            r_overflow  <= 1'b0;
            r_bad_cnt   <= 8'h00;
        end else begin
            if (r_state == S_INIT_HI) begin
                r_init_done <= 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_bad && (r_bad_cnt != 8'hFF)) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    assign init_done   = r_init_done;
    assign overflow    = r_overflow;
    assign bad_key_cnt = r_bad_cnt;

endmodule
